b01_line_driver: RTL

B01_LINE_DRIVER -- requirements
Module: b01_line_driver

---
 rtl/b01_line_driver.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/b01_line_driver.sv
// Serial line driver: buffers operand pairs in a 2-deep FIFO and shifts them
// out LSB first on LINE1/LINE2 as framed bursts, with optional idle gaps.
module b01_line_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clock,
  input  logic             nRESET_G,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             LINE1,
  output logic             LINE2,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned BIT_W = 5;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned ENT_W = 2 * WIDTH;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   fifo_q [2];
  logic               wr_q, rd_q;
  logic [1:0]         cnt_q, cnt_d;
  logic               ready_q;
  logic               push, pop;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               line1_q, line1_d, line2_q, line2_d;
  logic               fs_q, fs_d, fd_q, fd_d;
  logic               busy_q, busy_d;

  assign push   = in_valid && ready_q;
  assign head_a = fifo_q[rd_q][ENT_W-1:WIDTH];
  assign head_b = fifo_q[rd_q][WIDTH-1:0];

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pop always starts a new frame
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 2'd0) begin
          pop     = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_q == LAST_BIT) begin
          if (GAP != 0) begin
            state_d = S_GAP;
          end else if (cnt_q != 2'd0) begin
            pop     = 1'b1;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (cnt_q != 2'd0) begin
            pop     = 1'b1;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    line1_d = 1'b0;
    line2_d = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    busy_d  = (state_d != S_IDLE) || (cnt_d != 2'd0);
    if (pop) begin
      line1_d = head_a[0];
      line2_d = head_b[0];
      sa_d    = head_a >> 1;
      sb_d    = head_b >> 1;
      bit_d   = '0;
      fs_d    = 1'b1;
    end else if (state_q == S_SHIFT && state_d == S_SHIFT) begin
      line1_d = sa_q[0];
      line2_d = sb_q[0];
      sa_d    = sa_q >> 1;
      sb_d    = sb_q >> 1;
      bit_d   = bit_q + 5'd1;
      fd_d    = (bit_q + 5'd1) == LAST_BIT;
    end else if (state_d == S_GAP) begin
      gap_d = (state_q == S_SHIFT) ? GAP_LOAD : gap_q - 4'd1;
    end
  end

  // FIFO storage and registered outputs
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      ready_q   <= 1'b0;
      sa_q      <= '0;
      sb_q      <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      line1_q   <= 1'b0;
      line2_q   <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= {in_a, in_b};
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q   <= cnt_d;
      ready_q <= cnt_d < 2'd2;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      line1_q <= line1_d;
      line2_q <= line2_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready    = ready_q;
  assign LINE1       = line1_q;
  assign LINE2       = line2_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule
